prog_counter_gen: RTL and testbench
===================================

// Module: prog_counter_gen
// PURPOSE
//   Parametrised successor of the 8-bit programmable counter. Width-generic up/down counter
//   with a programmable limit, synchronous load, enabled prescaler, three runtime modes
//   (wrap, saturate, one-shot) and a registered terminal-count pulse.
//   Sits behind the top-level wrapper as the reusable timer/counter core.
// PARAMETERS
//   WIDTH   8  counter width in bits (>=2)
//   PRE_W   4  prescaler width; a tick occurs every (prescale+1) enabled cycles
// PORTS
//   clk       in   1      clock, all logic on rising edge
//   rst       in   1      reset, synchronous, active-high
//   en        in   1      count enable; gates prescaler and counting
//   load      in   1      synchronous parallel load of load_val
//   load_val  in   WIDTH  value to load
//   up        in   1      1 = count up, 0 = count down
//   mode      in   2      00 wrap, 01 saturate, 10 one-shot, 11 = wrap
//   limit     in   WIDTH  terminal value when counting up; reload value when wrapping down
//   start     in   1      one-shot arm (mode 10 only)
//   prescale  in   PRE_W  prescaler divide-minus-one
//   q         out  WIDTH  current count
//   tc        out  1      one-cycle terminal-count pulse (registered)
//   busy      out  1      one-shot FSM in RUN
//   done      out  1      one-shot FSM in DONE
// BEHAVIOUR
//   - Reset: q=0, tc=0, busy=0, done=0, FSM=IDLE, prescaler=0.
//   - Priority per edge: rst > load > tick. load sets q=load_val, clears prescaler, no tick that cycle.
//   - Prescaler pc: if en & count_ok: pc==prescale -> pc<=0 and tick=1; else pc<=pc+1.
//     en=0 holds pc. prescale=0 -> tick every enabled cycle.
//   - count_ok = 1 in modes 00/01/11; in mode 10 count_ok = (FSM==RUN).
//   - Terminal value T = limit (up) or 0 (down). Terminal tick = tick while q==T.
//   - Non-terminal tick: q<=q+1 (up) or q-1 (down), modulo 2^WIDTH.
//     Up from q>limit runs to all-ones, wraps to 0, and continues.
//   - Terminal tick, wrap: up -> q<=0; down -> q<=limit.
//   - Terminal tick, saturate: q holds; every terminal tick pulses tc.
//   - Terminal tick, one-shot: q holds; FSM RUN->DONE.
//   - tc: registered; high exactly the cycle after a terminal tick, coincident with the new q.
//   - One-shot FSM, active only while mode==10; any other mode forces IDLE next edge:
//     - IDLE --start--> RUN
//     - RUN --terminal tick--> DONE
//     - DONE --start--> RUN
//     - start in RUN is ignored.
//     - busy=(RUN), done=(DONE), both registered state decodes.
//   - Simultaneous events:
//     - load+start in IDLE/DONE -> q=load_val and RUN on the same edge.
//     - load in RUN -> q loaded, stays RUN, prescaler cleared.
//     - start with q already at T -> RUN; first tick is terminal.
//   - Changing limit/up/mode mid-count takes effect on the next tick; no state corruption.
//   - rst mid-operation: all state returns to reset values on that edge; any pending tc is dropped.
// TESTING
//   1 Wrap up: WIDTH=8, mode=00, up=1, limit=9, prescale=0, en=1 from reset
//     -> q 0..9,0,1; tc=1 only in the cycle q==0 after 9.
//   2 Wrap down: limit=5, load 2, up=0
//     -> q 2,1,0,5,4; tc=1 only in the cycle q==5.
//   3 Saturate: mode=01, limit=8'hFF, load 8'hFD, up=1
//     -> q FE,FF,FF,FF; tc high every cycle from the second FF on.
//   4 One-shot: mode=10, load 3, up=0, start pulse
//     -> busy=1, q 2,1,0; then done=1, busy=0, one tc pulse, q holds 0.
//     Re-start -> done=1 again after one tick.
//   5 Prescale=2, mode=00, up: q steps every 3rd cycle.
//     en=0 for 5 cycles freezes q and phase.
//     Load mid-phase restarts the 3-cycle phase from load.
//   6 rst=1 during one-shot RUN with load=1 same cycle
//     -> next cycle q=0, busy=0, done=0, tc=0.

Source files
------------

// File: rtl/prog_counter_gen.sv
// Width-generic up/down timer/counter core: programmable limit, synchronous load, prescaler,
// wrap / saturate / one-shot modes and a registered terminal-count pulse.
module prog_counter_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             start,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] ModeWrap    = 2'b00;
  localparam logic [1:0] ModeSat     = 2'b01;
  localparam logic [1:0] ModeOneShot = 2'b10;

  state_e           state, state_next;
  logic [PRE_W-1:0] pc;
  logic             count_ok;
  logic             pc_wrap;
  logic             tick;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic             term_tick;

  always_comb begin
    count_ok  = (mode == ModeOneShot) ? (state == StRun) : 1'b1;
    pc_wrap   = (pc == prescale);
    // load takes priority over the prescaler, so it suppresses the tick
    tick      = en & count_ok & pc_wrap & ~load;
    term_val  = up ? limit : '0;
    at_term   = (q == term_val);
    term_tick = tick & at_term;
  end

  always_comb begin
    state_next = state;
    if (mode != ModeOneShot) begin
      state_next = StIdle;
    end else begin
      unique case (state)
        StIdle:  if (start) state_next = StRun;
        StRun:   if (term_tick) state_next = StDone;
        StDone:  if (start) state_next = StRun;
        default: state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pc    <= '0;
      state <= StIdle;
    end else begin
      state <= state_next;
      busy  <= (state_next == StRun);
      done  <= (state_next == StDone);
      tc    <= term_tick;

      if (load) begin
        q  <= load_val;
        pc <= '0;
      end else if (en && count_ok) begin
        if (pc_wrap) begin
          pc <= '0;
        end else begin
          pc <= pc + 1'b1;
        end
      end

      if (tick) begin
        if (at_term) begin
          // saturate and one-shot hold q at the terminal value
          if (mode != ModeSat && mode != ModeOneShot) begin
            q <= up ? '0 : limit;
          end
        end else begin
          q <= up ? q + 1'b1 : q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_counter_gen.sv
// Directed, table-driven bench for prog_counter_gen plus hand-written prescaler sequences.
module tb_prog_counter_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, up, start;
  logic [7:0] load_val, limit;
  logic [1:0] mode;
  logic [3:0] prescale;
  logic [7:0] q;
  logic       tc, busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst, en, load;
    logic [7:0] lv;
    logic       up;
    logic [1:0] mode;
    logic [7:0] lim;
    logic       start;
    logic [3:0] pre;
    logic [7:0] eq;
    logic       etc, ebusy, edone;
  } vec_t;

  vec_t vecs[$];

  prog_counter_gen #(.WIDTH(8), .PRE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .mode     (mode),
    .limit    (limit),
    .start    (start),
    .prescale (prescale),
    .q        (q),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t v(logic r, logic e, logic ld, logic [7:0] lv, logic u,
                             logic [1:0] m, logic [7:0] lim, logic s, logic [3:0] pre,
                             logic [7:0] eq, logic etc, logic eb, logic ed);
    vec_t x;
    x.rst = r; x.en = e; x.load = ld; x.lv = lv; x.up = u; x.mode = m; x.lim = lim;
    x.start = s; x.pre = pre; x.eq = eq; x.etc = etc; x.ebusy = eb; x.edone = ed;
    return x;
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1; start = 1'b0;
    load_val = '0; limit = '0; mode = 2'b00; prescale = '0;

    // 1: wrap up, limit 9
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) vecs.push_back(v(0, 1, 0, 0, 1, 0, 9, 0, 0, 8'(i), 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 0, 9, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 0, 9, 0, 0, 1, 0, 0, 0));
    // 2: wrap down, limit 5, load 2
    vecs.push_back(v(0, 1, 1, 2, 0, 0, 5, 0, 0, 2, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 5, 0, 0, 5, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 5, 0, 0, 4, 0, 0, 0));
    // 3: saturate at FF
    vecs.push_back(v(0, 1, 1, 8'hFD, 1, 1, 8'hFF, 0, 0, 8'hFD, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 1, 8'hFF, 0, 0, 8'hFE, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 1, 8'hFF, 0, 0, 8'hFF, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 1, 1, 8'hFF, 0, 0, 8'hFF, 1, 0, 0));
    // 4: one-shot down from 3, then re-start at terminal
    vecs.push_back(v(0, 1, 1, 3, 0, 2, 0, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 1, 0, 3, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 2, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 1));
    // load+start in DONE, one tick, then rst+load during RUN
    vecs.push_back(v(0, 1, 1, 5, 0, 2, 0, 1, 0, 5, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(v(1, 1, 1, 8'hAA, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    // leaving one-shot mode forces IDLE
    vecs.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; load = vecs[i].load; load_val = vecs[i].lv;
      up = vecs[i].up; mode = vecs[i].mode; limit = vecs[i].lim; start = vecs[i].start;
      prescale = vecs[i].pre;
      step();
      check($sformatf("vec%0d.q", i), q, vecs[i].eq);
      check($sformatf("vec%0d.tc", i), 8'(tc), 8'(vecs[i].etc));
      check($sformatf("vec%0d.busy", i), 8'(busy), 8'(vecs[i].ebusy));
      check($sformatf("vec%0d.done", i), 8'(done), 8'(vecs[i].edone));
    end

    // 5: prescale=2, en freeze, load mid-phase
    rst = 1'b1; en = 1'b0; load = 1'b0; start = 1'b0; mode = 2'b00; up = 1'b1;
    limit = 8'hFF; prescale = 4'd2;
    step();
    rst = 1'b0; en = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("pre.edge%0d", e), q, 8'(e / 3));
    end
    en = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      check($sformatf("freeze%0d", e), q, 8'd3);
    end
    en = 1'b1;
    step(); check("resume1", q, 8'd3);
    step(); check("resume2", q, 8'd4);
    step(); check("resume3", q, 8'd4);
    load = 1'b1; load_val = 8'd10;
    step(); check("midload", q, 8'd10);
    load = 1'b0;
    step(); check("postload1", q, 8'd10);
    step(); check("postload2", q, 8'd10);
    step(); check("postload3", q, 8'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
